// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// A requester that asserts LOCK can keep the port for a bounded burst.
// Read data comes back one cycle after the read grant, as a RD_VALID pulse
// to the requester that issued the read.
//
// owner state | meaning
// ------------+-------------------------------------------------------------
// OWN_NONE    | no lock held; grants follow round-robin priority
// OWN_A       | A held LOCK on its last transfer; A keeps the grant while it
//             | requests and burst_cnt < MAX_BURST
// OWN_B       | same as OWN_A for requester B
module ram_port_arbiter #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int MAX_BURST     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_A,
  input  logic                     WE_A,
  input  logic                     LOCK_A,
  input  logic [ADDR_WIDTH-1:0]    ADDR_A,
  input  logic [IN_DATA_WIDTH-1:0] DATA_A,
  output logic                     GNT_A,
  output logic                     RD_VALID_A,
  output logic [IN_DATA_WIDTH-1:0] RD_DATA_A,
  input  logic                     REQ_B,
  input  logic                     WE_B,
  input  logic                     LOCK_B,
  input  logic [ADDR_WIDTH-1:0]    ADDR_B,
  input  logic [IN_DATA_WIDTH-1:0] DATA_B,
  output logic                     GNT_B,
  output logic                     RD_VALID_B,
  output logic [IN_DATA_WIDTH-1:0] RD_DATA_B,
  output logic [IN_DATA_WIDTH-1:0] RAM_DATA,
  output logic [ADDR_WIDTH-1:0]    RAM_ADDR,
  output logic                     RAM_WE,
  input  logic [IN_DATA_WIDTH-1:0] RAM_Q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t                   owner, owner_nxt;
  logic [CW-1:0]            burst_cnt, burst_cnt_nxt;
  logic                     prio, prio_nxt;        // 0 = A has priority, 1 = B
  logic                     gnt_a, gnt_b;
  logic                     lock_cont_a, lock_cont_b;
  logic                     rd_valid_a, rd_valid_b;
  logic [ADDR_WIDTH-1:0]    last_addr;
  logic [IN_DATA_WIDTH-1:0] last_data;

  // Grant selection and next lock/priority state.
  always_comb begin
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    owner_nxt     = OWN_NONE;
    burst_cnt_nxt = '0;
    prio_nxt      = prio;
    lock_cont_a   = (owner == OWN_A) && REQ_A && (burst_cnt < MAX_CNT);
    lock_cont_b   = (owner == OWN_B) && REQ_B && (burst_cnt < MAX_CNT);

    if (RST) begin
      if (lock_cont_a) begin
        gnt_a = 1'b1;
      end else if (lock_cont_b) begin
        gnt_b = 1'b1;
      end else if (REQ_A && REQ_B) begin
        gnt_a = ~prio;
        gnt_b = prio;
      end else begin
        gnt_a = REQ_A;
        gnt_b = REQ_B;
      end
    end

    // A grant past the burst limit restarts the count at 1 rather than
    // extending the exhausted burst.
    if (gnt_a) begin
      prio_nxt = 1'b1;
      if (LOCK_A) begin
        owner_nxt     = OWN_A;
        burst_cnt_nxt = lock_cont_a ? burst_cnt + CW'(1) : CW'(1);
      end
    end else if (gnt_b) begin
      prio_nxt = 1'b0;
      if (LOCK_B) begin
        owner_nxt     = OWN_B;
        burst_cnt_nxt = lock_cont_b ? burst_cnt + CW'(1) : CW'(1);
      end
    end
  end

  // Arbitration state, read-valid pulses and last-granted RAM drive values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      owner      <= OWN_NONE;
      burst_cnt  <= '0;
      prio       <= 1'b0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      last_addr  <= '0;
      last_data  <= '0;
    end else begin
      owner      <= owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      prio       <= prio_nxt;
      rd_valid_a <= gnt_a & ~WE_A;
      rd_valid_b <= gnt_b & ~WE_B;
      last_addr  <= RAM_ADDR;
      last_data  <= RAM_DATA;
    end
  end

  // With no grant the RAM sees the previous address again, so its registered
  // read address (and RAM_Q) stay put.
  always_comb begin
    RAM_ADDR = last_addr;
    RAM_DATA = last_data;
    RAM_WE   = 1'b0;
    if (gnt_a) begin
      RAM_ADDR = ADDR_A;
      RAM_DATA = DATA_A;
      RAM_WE   = WE_A;
    end else if (gnt_b) begin
      RAM_ADDR = ADDR_B;
      RAM_DATA = DATA_B;
      RAM_WE   = WE_B;
    end
  end

  assign GNT_A      = gnt_a;
  assign GNT_B      = gnt_b;
  assign RD_VALID_A = rd_valid_a;
  assign RD_VALID_B = rd_valid_b;
  assign RD_DATA_A  = RAM_Q;
  assign RD_DATA_B  = RAM_Q;

endmodule
